// File: rtl/ahb_fifo_pkg.sv
// Purpose: shared constants and entry layout for the AHB bridge FIFO (capture and read sides).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: entry width, default depth, field offsets of a captured AHB beat, pointer-width helper.
package ahb_fifo_pkg;

  localparam int AHB_FIFO_ENTRY_W    = 55;
  localparam int AHB_FIFO_DEPTH_DFLT = 4;

  // Field layout of one captured beat inside an entry (LSB offsets and widths).
  localparam int AHB_FIFO_DATA_LSB  = 0;
  localparam int AHB_FIFO_DATA_W    = 32;
  localparam int AHB_FIFO_ADDR_LSB  = 32;
  localparam int AHB_FIFO_ADDR_W    = 19;
  localparam int AHB_FIFO_SIZE_LSB  = 51;
  localparam int AHB_FIFO_SIZE_W    = 3;
  localparam int AHB_FIFO_WRITE_BIT = 54;

  typedef struct packed {
    logic                       write;
    logic [AHB_FIFO_SIZE_W-1:0] size;
    logic [AHB_FIFO_ADDR_W-1:0] addr;
    logic [AHB_FIFO_DATA_W-1:0] data;
  } ahb_fifo_entry_t;

  // Pointer width for a ring of 'depth' entries; never narrower than one bit.
  function automatic int ahb_fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ahb_fifo_rd_oreg.sv
// Purpose: one-entry valid/ready pipeline register used as the registered head stage of the FIFO.
// Latency: 1 cycle from in_vld&in_rdy to out_vld.
// Backpressure: in_rdy = !out_vld | out_rdy, so back-to-back transfers run at full throughput.
// Ports: clk/rst (sync, active-high), in_vld/in_rdy/in_dat upstream, out_vld/out_rdy/out_dat downstream.
// Only built when AHB_FIFO_RD_OREG_EN is defined, since only that configuration instantiates it.
`ifdef AHB_FIFO_RD_OREG_EN
module ahb_fifo_rd_oreg
  import ahb_fifo_pkg::*;
#(
  parameter int WIDTH = AHB_FIFO_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             load;

  // Slot is free when empty or when the current beat leaves this cycle.
  assign in_rdy = ~vld_q | out_rdy;
  assign load   = in_vld & in_rdy;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end else if (vld_q && out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule
`endif

// File: rtl/ahb_fifo_rd_ctrl.sv
// Purpose: pointer/read-side controller for the AHB bridge FIFO; drives external entry load strobes, muxes head.
// Latency: push->pop_vld 1 cycle (2 cycles with AHB_FIFO_RD_OREG_EN defined).
// Backpressure: push_rdy drops when storage holds DEPTH beats; head held until pop_rdy.
// Ports: fifo_clk/fifo_rst (sync, active-high); push_vld/push_rdy producer side; entry_create_en one-hot
//   load strobe and entry_data concatenated entry outputs (entry i at [i*WIDTH +: WIDTH]);
//   pop_vld/pop_rdy/pop_data consumer side; fifo_cnt/fifo_empty/fifo_full status.
// Option macro AHB_FIFO_RD_OREG_EN: adds a registered output stage (capacity DEPTH+1, counted in fifo_cnt).
module ahb_fifo_rd_ctrl
  import ahb_fifo_pkg::*;
#(
  parameter int DEPTH = AHB_FIFO_DEPTH_DFLT,
  parameter int WIDTH = AHB_FIFO_ENTRY_W,
  parameter int CNT_W = 3
) (
  input  logic                   fifo_clk,
  input  logic                   fifo_rst,
  input  logic                   push_vld,
  output logic                   push_rdy,
  output logic [DEPTH-1:0]       entry_create_en,
  input  logic [DEPTH*WIDTH-1:0] entry_data,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [WIDTH-1:0]       pop_data,
  output logic [CNT_W-1:0]       fifo_cnt,
  output logic                   fifo_empty,
  output logic                   fifo_full
);

  localparam int               PTR_W    = ahb_fifo_ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ST_FULL  = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

  logic             push_acc;
  logic             head_vld;
  logic             head_pop;
  logic [WIDTH-1:0] head_dat;

  // Storage-only fullness: a pop in the same cycle does not open a slot for the push.
  assign push_rdy = (st_cnt_q != ST_FULL);
  assign push_acc = push_vld & push_rdy;
  assign head_vld = (st_cnt_q != '0);

  always_comb begin
    entry_create_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_acc && (wr_ptr_q == PTR_W'(i))) begin
        entry_create_en[i] = 1'b1;
      end
    end
  end

  // Head mux; when storage is empty this still shows entry[rd_ptr], qualified off by head_vld.
  always_comb begin
    head_dat = entry_data[WIDTH-1:0];
    for (int i = 1; i < DEPTH; i++) begin
      if (rd_ptr_q == PTR_W'(i)) begin
        head_dat = entry_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    st_cnt_d = st_cnt_q;
    // Explicit wrap compare so non-power-of-two depths work.
    if (push_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (head_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push_acc, head_pop})
      2'b10:   st_cnt_d = st_cnt_q + CNT_W'(1);
      2'b01:   st_cnt_d = st_cnt_q - CNT_W'(1);
      default: st_cnt_d = st_cnt_q;
    endcase
  end

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      st_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      st_cnt_q <= st_cnt_d;
    end
  end

`ifdef AHB_FIFO_RD_OREG_EN
  logic stage_in_rdy;

  ahb_fifo_rd_oreg #(
    .WIDTH (WIDTH)
  ) u_oreg (
    .clk     (fifo_clk),
    .rst     (fifo_rst),
    .in_vld  (head_vld),
    .in_rdy  (stage_in_rdy),
    .in_dat  (head_dat),
    .out_vld (pop_vld),
    .out_rdy (pop_rdy),
    .out_dat (pop_data)
  );

  // Storage head leaves whenever the stage takes it, independent of the consumer.
  assign head_pop = head_vld & stage_in_rdy;
  assign fifo_cnt = st_cnt_q + CNT_W'(pop_vld);
`else
  assign pop_vld  = head_vld;
  assign pop_data = head_dat;
  assign head_pop = pop_vld & pop_rdy;
  assign fifo_cnt = st_cnt_q;
`endif

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = ~push_rdy;

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge fifo_clk) disable iff (fifo_rst)
    !(push_acc && (st_cnt_q == ST_FULL)));
  a_no_pop_empty: assert property (@(posedge fifo_clk) disable iff (fifo_rst)
    !(pop_vld && pop_rdy && (fifo_cnt == '0)));
  a_create_onehot0: assert property (@(posedge fifo_clk) disable iff (fifo_rst)
    $onehot0(entry_create_en));
`endif

endmodule

// File: tb/tb_ahb_fifo_rd_ctrl.sv
// Bench for ahb_fifo_rd_ctrl: directed vector table, latency/capacity sequences, randomized traffic,
// all checked each cycle against a queue-based reference model of the FIFO.
module tb_ahb_fifo_rd_ctrl;

  localparam int DEPTH = 4;
  localparam int WIDTH = 55;
  localparam int CNT_W = 3;
`ifdef AHB_FIFO_RD_OREG_EN
  localparam int LAT = 2;
  localparam int CAP = 5;
`else
  localparam int LAT = 1;
  localparam int CAP = 4;
`endif

  logic                   clk = 1'b0;
  logic                   fifo_rst;
  logic                   push_vld;
  logic                   push_rdy;
  logic [DEPTH-1:0]       entry_create_en;
  logic [DEPTH*WIDTH-1:0] entry_data;
  logic                   pop_vld;
  logic                   pop_rdy;
  logic [WIDTH-1:0]       pop_data;
  logic [WIDTH-1:0]       push_data;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   fifo_empty;
  logic                   fifo_full;

  always #5 clk = ~clk;

  ahb_fifo_rd_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .fifo_clk        (clk),
    .fifo_rst        (fifo_rst),
    .push_vld        (push_vld),
    .push_rdy        (push_rdy),
    .entry_create_en (entry_create_en),
    .entry_data      (entry_data),
    .pop_vld         (pop_vld),
    .pop_rdy         (pop_rdy),
    .pop_data        (pop_data),
    .fifo_cnt        (fifo_cnt),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full)
  );

  // External storage entries, loaded by the controller's strobes.
  logic [WIDTH-1:0] ent [DEPTH];
  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_create_en[i]) ent[i] <= push_data;
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_data[i*WIDTH +: WIDTH] = ent[i];
  end

  // Reference model: storage queue, optional output slot, count of accepted pushes since reset.
  logic [WIDTH-1:0] mq [$];
  bit               m_sv;
  logic [WIDTH-1:0] m_sd;
  int               n_push;

  int n_tests = 0;
  int n_fail  = 0;

  // Values sampled from the DUT in the most recent cycle.
  logic             s_prdy, s_vld, s_empty, s_full;
  logic [WIDTH-1:0] s_dat;
  logic [CNT_W-1:0] s_cnt;
  logic [DEPTH-1:0] s_ce;

  typedef struct {
    bit         rst;
    bit         pv;
    logic [7:0] pd;
    bit         pr;
    bit         e_prdy;
    bit         e_vld;
    logic [7:0] e_dat;
    int         e_cnt;
    logic [3:0] e_ce;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input bit rst, input bit pv, input logic [7:0] pd, input bit pr,
                              input bit ep, input bit ev, input logic [7:0] ed, input int ec,
                              input logic [3:0] ece);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pd = pd; v.pr = pr;
    v.e_prdy = ep; v.e_vld = ev; v.e_dat = ed; v.e_cnt = ec; v.e_ce = ece;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[WIDTH-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model at the falling edge, advance at the rising edge.
  task automatic cycle(input bit r, input bit pv, input logic [WIDTH-1:0] pd, input bit pr);
    bit               e_prdy, e_vld, pacc;
    logic [WIDTH-1:0] e_dat;
    int               e_cnt;
    logic [DEPTH-1:0] e_ce;
`ifdef AHB_FIFO_RD_OREG_EN
    bit popa, load;
`endif
    fifo_rst  = r;
    push_vld  = pv;
    push_data = pd;
    pop_rdy   = pr;
    @(negedge clk);
    e_prdy = (mq.size() < DEPTH);
`ifdef AHB_FIFO_RD_OREG_EN
    e_vld = m_sv;
    e_dat = m_sd;
    e_cnt = mq.size() + int'(m_sv);
`else
    e_vld = (mq.size() != 0);
    e_dat = e_vld ? mq[0] : '0;
    e_cnt = mq.size();
`endif
    pacc = pv && e_prdy;
    e_ce = '0;
    if (pacc) e_ce[n_push % DEPTH] = 1'b1;
    s_prdy = push_rdy; s_vld = pop_vld; s_dat = pop_data; s_cnt = fifo_cnt;
    s_empty = fifo_empty; s_full = fifo_full; s_ce = entry_create_en;
    chk("push_rdy", 64'(s_prdy), 64'(e_prdy));
    chk("pop_vld", 64'(s_vld), 64'(e_vld));
    if (e_vld) chk("pop_data", 64'(s_dat), 64'(e_dat));
    chk("fifo_cnt", 64'(s_cnt), 64'(e_cnt));
    chk("fifo_empty", 64'(s_empty), 64'(e_cnt == 0));
    chk("fifo_full", 64'(s_full), 64'(!e_prdy));
    chk("create_en", 64'(s_ce), 64'(e_ce));
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_sv = 1'b0;
      m_sd = '0;
      n_push = 0;
    end else begin
`ifdef AHB_FIFO_RD_OREG_EN
      popa = m_sv && pr;
      load = (!m_sv || popa) && (mq.size() != 0);
      if (load) begin
        m_sd = mq.pop_front();
        m_sv = 1'b1;
      end else if (popa) begin
        m_sv = 1'b0;
      end
`else
      if (pr && (mq.size() != 0)) void'(mq.pop_front());
`endif
      if (pacc) begin
        mq.push_back(pd);
        n_push++;
      end
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc;
    int pv_bias, pr_bias;
    bit r;

    fifo_rst = 1'b1; push_vld = 1'b0; push_data = '0; pop_rdy = 1'b0;
    m_sv = 1'b0; m_sd = '0; n_push = 0;
    repeat (3) @(posedge clk);
    #1;
    fifo_rst = 1'b0;

    // Directed sequence; expected columns describe the combinational-head build.
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h00,0,4'b0000)); // idle after reset
    tbl.push_back(mk(0,1,8'h11,0, 1,0,8'h00,0,4'b0001));
    tbl.push_back(mk(0,1,8'h22,0, 1,1,8'h11,1,4'b0010));
    tbl.push_back(mk(0,1,8'h33,0, 1,1,8'h11,2,4'b0100));
    tbl.push_back(mk(0,1,8'h44,0, 1,1,8'h11,3,4'b1000));
    tbl.push_back(mk(0,1,8'h99,0, 0,1,8'h11,4,4'b0000)); // full: 5th push refused
    tbl.push_back(mk(0,0,8'h00,1, 0,1,8'h11,4,4'b0000)); // drain in order
    tbl.push_back(mk(0,0,8'h00,1, 1,1,8'h22,3,4'b0000));
    tbl.push_back(mk(0,0,8'h00,1, 1,1,8'h33,2,4'b0000));
    tbl.push_back(mk(0,0,8'h00,1, 1,1,8'h44,1,4'b0000));
    tbl.push_back(mk(0,0,8'h00,1, 1,0,8'h00,0,4'b0000)); // pop_rdy on empty ignored
    tbl.push_back(mk(0,1,8'hA1,0, 1,0,8'h00,0,4'b0001)); // push/pop pairs across the wrap
    tbl.push_back(mk(0,1,8'hA2,1, 1,1,8'hA1,1,4'b0010));
    tbl.push_back(mk(0,1,8'hA3,1, 1,1,8'hA2,1,4'b0100));
    tbl.push_back(mk(0,1,8'hA4,1, 1,1,8'hA3,1,4'b1000));
    tbl.push_back(mk(0,1,8'hA5,1, 1,1,8'hA4,1,4'b0001));
    tbl.push_back(mk(0,1,8'hA6,1, 1,1,8'hA5,1,4'b0010));
    tbl.push_back(mk(0,1,8'hA7,1, 1,1,8'hA6,1,4'b0100));
    tbl.push_back(mk(0,1,8'hA8,0, 1,1,8'hA7,1,4'b1000));
    tbl.push_back(mk(0,0,8'h00,1, 1,1,8'hA7,2,4'b0000));
    tbl.push_back(mk(0,0,8'h00,1, 1,1,8'hA8,1,4'b0000));
    tbl.push_back(mk(0,1,8'hB1,0, 1,0,8'h00,0,4'b0001)); // fill, then full with pop+push
    tbl.push_back(mk(0,1,8'hB2,0, 1,1,8'hB1,1,4'b0010));
    tbl.push_back(mk(0,1,8'hB3,0, 1,1,8'hB1,2,4'b0100));
    tbl.push_back(mk(0,1,8'hB4,0, 1,1,8'hB1,3,4'b1000));
    tbl.push_back(mk(0,1,8'hB5,1, 0,1,8'hB1,4,4'b0000)); // only the pop is taken
    tbl.push_back(mk(0,1,8'hB5,0, 1,1,8'hB2,3,4'b0001)); // push taken next cycle
    tbl.push_back(mk(0,0,8'h00,1, 0,1,8'hB2,4,4'b0000));
    tbl.push_back(mk(1,0,8'h00,0, 1,1,8'hB3,3,4'b0000)); // reset with three beats held
    tbl.push_back(mk(0,1,8'h55,0, 1,0,8'h00,0,4'b0001));
    tbl.push_back(mk(0,0,8'h00,1, 1,1,8'h55,1,4'b0000));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h00,0,4'b0000));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].pv, WIDTH'(tbl[i].pd), tbl[i].pr);
`ifndef AHB_FIFO_RD_OREG_EN
      chk($sformatf("tbl%0d_push_rdy", i), 64'(s_prdy), 64'(tbl[i].e_prdy));
      chk($sformatf("tbl%0d_pop_vld", i), 64'(s_vld), 64'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_pop_data", i), 64'(s_dat), 64'(tbl[i].e_dat));
      chk($sformatf("tbl%0d_fifo_cnt", i), 64'(s_cnt), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_create_en", i), 64'(s_ce), 64'(tbl[i].e_ce));
`endif
    end

    // Push-to-pop latency from empty.
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, rnd(), 1'b0);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b0);
      lat++;
      if (s_vld) break;
    end
    chk("push_to_pop_latency", 64'(lat), 64'(LAT));

    // Total capacity with the consumer stalled, then drain.
    cycle(1'b1, 1'b0, '0, 1'b0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, rnd(), 1'b0);
      if (s_prdy) acc++;
      else break;
    end
    chk("capacity", 64'(acc), 64'(CAP));
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic in phases with different producer/consumer duty cycles.
    for (int ph = 0; ph < 6; ph++) begin
      pv_bias = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 30 : 60);
      pr_bias = (ph % 2 == 0) ? 40 : 85;
      for (int c = 0; c < 500; c++) begin
        r = ($urandom_range(0, 199) == 0);
        cycle(r, ($urandom_range(0, 99) < pv_bias), rnd(), ($urandom_range(0, 99) < pr_bias));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
